mb8_arb: RTL and testbench
==========================

MB8_ARB -- requirements
Module: mb8_arb

Interface
REQ-001 Parameter DSZ, default 8, data bus width in bits.
REQ-002 Parameter ASZ, default 20-$clog2(DSZ) (17), address width in bytes of 128K SPRAM.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester request; held high with we/ai/vi stable until its ack.
REQ-006 we  input  2  per-requester write enable (1 = write, 0 = read).
REQ-007 ai0, ai1  input  ASZ each  per-requester byte address.
REQ-008 vi0, vi1  input  DSZ each  per-requester write data.
REQ-009 ack  output  2  one-cycle completion pulse per requester.
REQ-010 vo  output  DSZ  read data returned to requesters, valid when the matching ack is high.
REQ-011 gnt  output  2  one-hot current owner of the memory bus (00 when idle).
REQ-012 mem_we  output  1  memory-side write enable.
REQ-013 mem_ai  output  ASZ  memory-side address.
REQ-014 mem_vi  output  DSZ  memory-side write data.
REQ-015 mem_vo  input  DSZ  memory-side read data, valid one cycle after the address is presented (synchronous SPRAM).

Function
REQ-016 The FSM SHALL have three states: IDLE, XFER, ACK.
REQ-017 IDLE: if any req bit is high, latch the winner into gnt and go to XFER next cycle; otherwise stay in IDLE with gnt=00.
REQ-018 XFER (one cycle): drive mem_ai/mem_vi from the granted requester and mem_we = we of the granted requester; go to ACK.
REQ-019 ACK (one cycle): pulse ack[g]=1, drive vo=mem_vo, force mem_we=0, clear gnt, return to IDLE.
REQ-020 Latency: req sampled high in IDLE at cycle N -> XFER at N+1 -> ack at N+2; minimum spacing of 3 cycles between back-to-back grants.
REQ-021 Arbitration SHALL be round-robin: with both req high in IDLE, grant the requester not granted last; with one req high, grant it regardless of history.
REQ-022 The last-granted pointer SHALL update only on entry to XFER.
REQ-023 mem_we SHALL be 1 only in XFER with a write grant; it is never 1 in IDLE or ACK.
REQ-024 mem_ai and mem_vi hold their last values outside XFER; vo holds its last value outside ACK.
REQ-025 At most one ack bit SHALL be high in any cycle; ack is never asserted to a requester whose req was low at grant.
REQ-026 A req dropped before its ack (protocol violation) does not abort the transfer; the ack is still issued.
REQ-027 A requester that keeps req high after ack is treated as a new request in the following IDLE cycle.

Reset
REQ-028 On rst high at a clock edge: state=IDLE, gnt=00, ack=00, mem_we=0, mem_ai=0, mem_vi=0, vo=0, last-granted pointer=1 (so requester 0 wins the first tie).
REQ-029 rst asserted during XFER or ACK SHALL abort the transfer with no ack issued; rst has priority over every other input.

Structure
REQ-030 DSZ, ASZ and the FSM state enum (IDLE, XFER, ACK) SHALL live in shared package mb8_pkg.
REQ-031 Round-robin winner selection SHALL be a sub-module mb8_rr2 (inputs req, last; output one-hot winner), purely combinational.
REQ-032 The memory-side ports SHALL be bundled so they connect directly to an mb8_io interface instance (we, ai, vi, vo).

Verification
REQ-033 Single read: req=01, we=0, ai0=17'h00010, memory holds 8'hA5 -> mem_ai=00010 in XFER, ack=01 with vo=A5 two cycles after req.
REQ-034 Single write: req=10, we=10, ai1=17'h1FFFF, vi1=8'h3C -> mem_we=1 for exactly one cycle with mem_ai=1FFFF, mem_vi=3C; ack=10; a read-back of 1FFFF returns 3C.
REQ-035 Contention: req=11 held for 4 transactions after reset -> grant order 0,1,0,1; acks spaced 3 cycles apart; never both ack bits high.
REQ-036 Starvation check: req0 held continuously, req1 raised once -> req1 acked within 6 cycles of raising.
REQ-037 Reset mid-op: rst pulsed in XFER of a write -> no ack, mem_we=0 the next cycle, state IDLE, next tie goes to requester 0.
REQ-038 Idle: req=00 for 10 cycles -> gnt=00, ack=00, mem_we=0 throughout.

Source files
------------

// File: rtl/mb8_pkg.sv
// Shared constants, FSM state type and small helpers for the two-port SPRAM arbiter.
// Every mb8 block imports this package.
package mb8_pkg;

   localparam int DSZ = 8;
   localparam int ASZ = 20 - $clog2(DSZ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      ACK  = 2'd2
   } state_t;

   // Index of the set bit in a two-bit one-hot vector (0 for 2'b01, 1 for 2'b10).
   function automatic logic oh2idx(input logic [1:0] oh);
      return oh[1];
   endfunction

endpackage

// File: rtl/mb8_io.sv
// Memory-side bundle between the arbiter and a synchronous single-port RAM.
// The arbiter drives we/ai/vi and the RAM returns vo one cycle after the address.
interface mb8_io #(
   parameter int DSZ = mb8_pkg::DSZ,
   parameter int ASZ = mb8_pkg::ASZ
);

   logic           we;
   logic [ASZ-1:0] ai;
   logic [DSZ-1:0] vi;
   logic [DSZ-1:0] vo;

   modport arb (output we, output ai, output vi, input vo);
   modport mem (input we, input ai, input vi, output vo);

endinterface

// File: rtl/mb8_rr2.sv
// Two-way round-robin winner select, purely combinational.
// On a tie the requester that was not granted last wins.
module mb8_rr2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);

   // Pick the one-hot winner from the request pair and the last-granted index.
   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11: begin
            if (last) begin
               win = 2'b01;
            end else begin
               win = 2'b10;
            end
         end
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/mb8_arb.sv
// Two-requester round-robin arbiter in front of a synchronous single-port SPRAM.
// A transfer takes IDLE -> XFER -> ACK, one cycle each.
module mb8_arb #(
   parameter int DSZ = mb8_pkg::DSZ,
   parameter int ASZ = 20 - $clog2(DSZ)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     req,
   input  logic [1:0]     we,
   input  logic [ASZ-1:0] ai0,
   input  logic [ASZ-1:0] ai1,
   input  logic [DSZ-1:0] vi0,
   input  logic [DSZ-1:0] vi1,
   output logic [1:0]     ack,
   output logic [DSZ-1:0] vo,
   output logic [1:0]     gnt,
   output logic           mem_we,
   output logic [ASZ-1:0] mem_ai,
   output logic [DSZ-1:0] mem_vi,
   input  logic [DSZ-1:0] mem_vo
);

   import mb8_pkg::*;

   state_t         state_r;
   state_t         state_s;
   logic [1:0]     gnt_r;
   logic           last_r;
   logic [1:0]     ack_r;
   logic           mem_we_r;
   logic [ASZ-1:0] mem_ai_r;
   logic [DSZ-1:0] mem_vi_r;
   logic [DSZ-1:0] vo_hold_r;
   logic [1:0]     win_s;
   logic           sel_we_s;
   logic [ASZ-1:0] sel_ai_s;
   logic [DSZ-1:0] sel_vi_s;
   logic [DSZ-1:0] vo_s;

   mb8_rr2 u_rr (
      .req  (req),
      .last (last_r),
      .win  (win_s)
   );

   // Route the winning requester's command fields toward the memory registers.
   always_comb begin
      sel_we_s = 1'b0;
      sel_ai_s = ai0;
      sel_vi_s = vi0;
      if (win_s[1]) begin
         sel_we_s = we[1];
         sel_ai_s = ai1;
         sel_vi_s = vi1;
      end else begin
         sel_we_s = we[0];
         sel_ai_s = ai0;
         sel_vi_s = vi0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (|req) begin
               state_s = XFER;
            end else begin
               state_s = IDLE;
            end
         end
         XFER:    state_s = ACK;
         ACK:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Grant, pointer, ack and memory-side command registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_r     <= 2'b00;
         last_r    <= 1'b1;
         ack_r     <= 2'b00;
         mem_we_r  <= 1'b0;
         mem_ai_r  <= '0;
         mem_vi_r  <= '0;
         vo_hold_r <= '0;
      end else begin
         ack_r <= 2'b00;
         case (state_r)
            IDLE: begin
               if (|req) begin
                  // Command is registered here so it is stable for the whole XFER cycle.
                  gnt_r    <= win_s;
                  last_r   <= oh2idx(win_s);
                  mem_we_r <= sel_we_s;
                  mem_ai_r <= sel_ai_s;
                  mem_vi_r <= sel_vi_s;
               end else begin
                  gnt_r    <= 2'b00;
                  mem_we_r <= 1'b0;
               end
            end
            XFER: begin
               ack_r    <= gnt_r;
               mem_we_r <= 1'b0;
            end
            ACK: begin
               gnt_r     <= 2'b00;
               vo_hold_r <= mem_vo;
            end
            default: begin
               gnt_r    <= 2'b00;
               mem_we_r <= 1'b0;
            end
         endcase
      end
   end

   // RAM data arrives in the ACK cycle itself, so vo bypasses straight through then.
   always_comb begin
      vo_s = vo_hold_r;
      if (state_r == ACK) begin
         vo_s = mem_vo;
      end else begin
         vo_s = vo_hold_r;
      end
   end

   assign ack    = ack_r;
   assign gnt    = gnt_r;
   assign vo     = vo_s;
   assign mem_we = mem_we_r;
   assign mem_ai = mem_ai_r;
   assign mem_vi = mem_vi_r;

endmodule

// File: tb/tb_mb8_arb.sv
// Self-checking bench for mb8_arb: directed scenarios plus random traffic,
// compared cycle by cycle with a transaction-level reference model.
module tb_mb8_arb;

   localparam int DSZ   = 8;
   localparam int ASZ   = 17;
   localparam int DEPTH = 1 << ASZ;

   logic           clk = 1'b0;
   logic           rst;
   logic [1:0]     req;
   logic [1:0]     we;
   logic [ASZ-1:0] ai0, ai1;
   logic [DSZ-1:0] vi0, vi1;
   logic [1:0]     ack, gnt;
   logic [DSZ-1:0] vo;

   always #5 clk = ~clk;

   mb8_io #(.DSZ(DSZ), .ASZ(ASZ)) io ();

   mb8_arb #(.DSZ(DSZ), .ASZ(ASZ)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .we     (we),
      .ai0    (ai0),
      .ai1    (ai1),
      .vi0    (vi0),
      .vi1    (vi1),
      .ack    (ack),
      .vo     (vo),
      .gnt    (gnt),
      .mem_we (io.we),
      .mem_ai (io.ai),
      .mem_vi (io.vi),
      .mem_vo (io.vo)
   );

   // Synchronous SPRAM, read-before-write.
   logic [DSZ-1:0] mem     [DEPTH];
   logic [DSZ-1:0] ref_mem [DEPTH];

   always @(posedge clk) begin
      if (io.we === 1'b1) mem[io.ai] <= io.vi;
      io.vo <= mem[io.ai];
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a transaction occupies the bus for 3 cycles after it is accepted.
   int             busy;
   int             mlast;
   int             mown;
   logic [1:0]     e_gnt, e_ack;
   logic           e_we;
   logic [ASZ-1:0] e_ai;
   logic [DSZ-1:0] e_vi, last_vo;
   logic           t_we;
   logic [ASZ-1:0] t_ai;
   logic [DSZ-1:0] t_vi;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Predict the effect of the coming clock edge, take the edge, then compare.
   task automatic step();
      if (rst) begin
         if (busy == 2 && t_we) ref_mem[t_ai] = t_vi;
         busy = 0; mlast = 1;
         e_gnt = 2'b00; e_ack = 2'b00; e_we = 1'b0;
         e_ai = '0; e_vi = '0; last_vo = '0;
      end else if (busy == 0) begin
         e_ack = 2'b00;
         if (req != 2'b00) begin
            if (req == 2'b11) mown = (mlast == 0) ? 1 : 0;
            else              mown = req[1] ? 1 : 0;
            mlast = mown;
            busy  = 2;
            e_gnt = 2'(1 << mown);
            t_we  = we[mown];
            t_ai  = (mown == 1) ? ai1 : ai0;
            t_vi  = (mown == 1) ? vi1 : vi0;
            e_we  = t_we; e_ai = t_ai; e_vi = t_vi;
         end else begin
            e_gnt = 2'b00;
            e_we  = 1'b0;
         end
      end else if (busy == 2) begin
         busy    = 1;
         e_ack   = 2'(1 << mown);
         e_we    = 1'b0;
         last_vo = ref_mem[t_ai];
         if (t_we) ref_mem[t_ai] = t_vi;
      end else begin
         busy  = 0;
         e_ack = 2'b00;
         e_gnt = 2'b00;
      end
      @(posedge clk);
      #1;
      chk("gnt", gnt, e_gnt);
      chk("ack", ack, e_ack);
      chk("mem_we", io.we, e_we);
      chk("mem_ai", io.ai, e_ai);
      chk("mem_vi", io.vi, e_vi);
      chk("vo", vo, last_vo);
      chk("ack_onehot0", ($countones(ack) <= 1) ? 1 : 0, 1);
   endtask

   initial begin
      logic [1:0]     pend;
      logic [ASZ-1:0] a;
      logic [DSZ-1:0] d;
      int             n_ack, cyc, prev, cnt;
      bit             got;

      rst = 1'b1; req = 2'b00; we = 2'b00;
      ai0 = '0; ai1 = '0; vi0 = '0; vi1 = '0;
      busy = 0; mlast = 1; mown = 0;
      t_we = 1'b0; t_ai = '0; t_vi = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
      mem[17'h00010]     = 8'hA5;
      ref_mem[17'h00010] = 8'hA5;

      // Reset, then idle
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_gnt", gnt, 2'b00);
         chk("idle_we", io.we, 1'b0);
      end

      // Single read of a preloaded location
      req = 2'b01; we = 2'b00; ai0 = 17'h00010;
      step();
      chk("rd_xfer_ai", io.ai, 17'h00010);
      step();
      chk("rd_ack", ack, 2'b01);
      chk("rd_vo", vo, 8'hA5);
      req = 2'b00;
      step();

      // Single write at the top address, then read it back
      req = 2'b10; we = 2'b10; ai1 = 17'h1FFFF; vi1 = 8'h3C;
      step();
      chk("wr_we", io.we, 1'b1);
      chk("wr_ai", io.ai, 17'h1FFFF);
      chk("wr_vi", io.vi, 8'h3C);
      step();
      chk("wr_ack", ack, 2'b10);
      chk("wr_we_off", io.we, 1'b0);
      req = 2'b00; we = 2'b00;
      step();
      req = 2'b10;
      step(); step();
      chk("rb_vo", vo, 8'h3C);
      req = 2'b00;
      step();

      // Contention straight after reset: order 0,1,0,1 with 3-cycle spacing
      rst = 1'b1; step(); rst = 1'b0;
      req = 2'b11; we = 2'b00; ai0 = 17'h00020; ai1 = 17'h00021;
      n_ack = 0; cyc = 0; prev = -1;
      for (int c = 0; c < 30 && n_ack < 4; c++) begin
         step();
         cyc++;
         if (ack != 2'b00) begin
            chk("cont_order", ack, (n_ack % 2 == 0) ? 2'b01 : 2'b10);
            if (prev >= 0) chk("cont_spacing", cyc - prev, 3);
            prev = cyc;
            n_ack++;
         end
      end
      chk("cont_count", n_ack, 4);
      req = 2'b00;
      step(); step(); step();

      // Starvation: req0 held continuously, req1 raised once
      req = 2'b01; ai0 = 17'h00030;
      step(); step();
      req = 2'b11; ai1 = 17'h00031;
      cnt = 0; got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         step();
         cnt++;
         if (ack[1] === 1'b1) got = 1'b1;
      end
      chk("starve_acked", got, 1'b1);
      chk("starve_within6", (cnt <= 6) ? 1 : 0, 1);
      req = 2'b00;
      step(); step(); step();

      // Reset during the XFER cycle of a write
      req = 2'b01; we = 2'b01; ai0 = 17'h00005; vi0 = 8'h77;
      step();
      chk("rst_xfer_we", io.we, 1'b1);
      rst = 1'b1; req = 2'b00; we = 2'b00;
      step();
      chk("rst_no_ack", ack, 2'b00);
      chk("rst_we_off", io.we, 1'b0);
      rst = 1'b0; req = 2'b11;
      step();
      chk("rst_tie_to0", gnt, 2'b01);
      req = 2'b00;
      step(); step(); step();

      // Request dropped right after grant still completes
      req = 2'b10; we = 2'b00; ai1 = 17'h00040;
      step();
      req = 2'b00;
      step();
      chk("drop_ack", ack, 2'b10);
      step();

      // Random traffic with protocol-respecting requesters
      pend = 2'b00; req = 2'b00;
      for (int c = 0; c < 600; c++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            if (e_ack[i]) pend[i] = 1'b0;
            if (!pend[i]) begin
               if ($urandom_range(0, 2) != 0) begin
                  pend[i] = 1'b1;
                  req[i]  = 1'b1;
                  we[i]   = 1'($urandom_range(0, 1));
                  a = 17'($urandom_range(0, 15));
                  if ($urandom_range(0, 7) == 0) a = 17'h1FFFF;
                  d = 8'($urandom);
                  if (i == 0) begin
                     ai0 = a; vi0 = d;
                  end else begin
                     ai1 = a; vi1 = d;
                  end
               end else begin
                  req[i] = 1'b0;
               end
            end
         end
      end
      req = 2'b00;
      step(); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
